// File: rtl/fetch_stage_pipeline_reg_if.sv
// Hazard-control and IF/ID bus between the hazard unit (master) and the fetch stage (slave).
// Carries the stall/flush controls inbound and the PC, IF/ID latch and status outbound.
interface fetch_stage_pipeline_reg_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 pc_write;
    logic                 IF_ID_write;
    logic                 flush;
    logic [WIDTH-1:0]     branch_target;
    logic [WIDTH-1:0]     instr_in;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     IF_ID_pc_plus4;
    logic [WIDTH-1:0]     IF_ID_instr;
    logic                 IF_ID_valid;
    logic [1:0]           stage_state;
    logic                 stall_timeout;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    modport master (
        output pc_write, IF_ID_write, flush, branch_target, instr_in,
        input  pc, IF_ID_pc_plus4, IF_ID_instr, IF_ID_valid, stage_state, stall_timeout,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  pc_write, IF_ID_write, flush, branch_target, instr_in,
        output pc, IF_ID_pc_plus4, IF_ID_instr, IF_ID_valid, stage_state, stall_timeout,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_stage_pipeline_reg.sv
// PC register and IF/ID latch with registered stage-status FSM and sticky stall watchdog.
// Define FETCH_PERF_COUNTERS_EN to build the saturating stall/flush performance counters.
module fetch_stage_pipeline_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      STALL_LIMIT = 8,
    parameter int unsigned      CNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    fetch_stage_pipeline_reg_if.slave bus
);
    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } stage_e;

    localparam int unsigned    RunW   = $clog2(STALL_LIMIT + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(STALL_LIMIT);

    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] pc_plus4;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] if_pc4_q, if_pc4_d;
    logic [WIDTH-1:0] if_instr_q, if_instr_d;
    logic             if_valid_q, if_valid_d;
    stage_e           state_q, state_d;
    logic [RunW-1:0]  run_q, run_d;
    logic             timeout_q, timeout_d;

    // A stalled edge ignores flush: the branch in ID re-resolves next cycle.
    assign stall    = ~bus.pc_write;
    assign redirect = bus.pc_write & bus.flush;
    assign pc_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        pc_d       = pc_q;
        if_pc4_d   = if_pc4_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        if (redirect) begin
            pc_d       = bus.branch_target;
            if_pc4_d   = '0;
            if_instr_d = '0;
            if_valid_d = 1'b0;
        end else begin
            if (bus.pc_write) begin
                pc_d = pc_plus4;
            end
            // Load is honoured even while the PC is held, and vice versa.
            if (bus.IF_ID_write) begin
                if_pc4_d   = pc_plus4;
                if_instr_d = bus.instr_in;
                if_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (stall) begin
            state_d = StStall;
        end else if (redirect) begin
            state_d = StFlush;
        end else begin
            state_d = StRun;
        end
    end

    always_comb begin
        run_d     = '0;
        timeout_d = timeout_q;
        if (stall) begin
            run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
            if (run_d == RunMax) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            if_pc4_q   <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            state_q    <= StRun;
            run_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc4_q   <= if_pc4_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            state_q    <= state_d;
            run_q      <= run_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.IF_ID_pc_plus4 = if_pc4_q;
    assign bus.IF_ID_instr    = if_instr_q;
    assign bus.IF_ID_valid    = if_valid_q;
    assign bus.stage_state    = state_q;
    assign bus.stall_timeout  = timeout_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (redirect && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_WIDTH{1'b0}};
    assign bus.flush_cnt = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_fetch_stage_pipeline_reg.sv
// Scoreboard bench for fetch_stage_pipeline_reg: the driver pushes model predictions per edge,
// an independent monitor pops and compares after every clock edge or asynchronous reset.
module tb_fetch_stage_pipeline_reg;
    localparam int unsigned W   = 32;
    localparam int unsigned LIM = 8;
    localparam int unsigned CW  = 16;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_pipeline_reg_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    fetch_stage_pipeline_reg #(
        .WIDTH      (W),
        .RESET_PC   (32'h0000_0000),
        .STALL_LIMIT(LIM),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  state;
        logic        to;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_pc4, m_instr;
    bit          m_valid, m_to;
    logic [1:0]  m_state;
    int          m_run, m_scnt, m_fcnt;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 0;
        m_state = 2'd0; m_to = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
    endfunction

    function automatic void model_edge(bit pw, bit iw, bit fl, logic [31:0] tgt,
                                       logic [31:0] ins);
        logic [31:0] nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        nxt = m_pc + 32'd4;
        if (pw && fl) begin
            m_pc = tgt; m_pc4 = 0; m_instr = 0; m_valid = 0;
            m_state = 2'd2; m_run = 0;
            if (m_fcnt < CNT_MAX) m_fcnt++;
        end else begin
            if (iw) begin
                m_instr = ins; m_pc4 = nxt; m_valid = 1;
            end
            if (pw) begin
                m_pc = nxt; m_state = 2'd0; m_run = 0;
            end else begin
                m_state = 2'd1;
                if (m_run < LIM) m_run++;
                if (m_run == LIM) m_to = 1;
                if (m_scnt < CNT_MAX) m_scnt++;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.valid = m_valid;
        e.state = m_state; e.to = m_to;
`ifdef FETCH_PERF_COUNTERS_EN
        e.scnt = 16'(m_scnt); e.fcnt = 16'(m_fcnt);
`else
        e.scnt = 16'h0; e.fcnt = 16'h0;
`endif
        sb_q.push_back(e);
    endfunction

    task automatic step(input bit pw, input bit iw, input bit fl, input logic [31:0] tgt);
        logic [31:0] ins;
        ins = $urandom();
        @(negedge clk);
        bus.pc_write = pw; bus.IF_ID_write = iw; bus.flush = fl;
        bus.branch_target = tgt; bus.instr_in = ins;
        model_edge(pw, iw, fl, tgt, ins);
        push_exp();
        mon_en = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic release_rst();
        settle();
        rst = 1'b1;
    endtask

    // Assert reset between edges; the monitor checks the immediate effect.
    task automatic async_rst();
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        push_exp();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("pc", bus.pc, e.pc);
                    check("IF_ID_pc_plus4", bus.IF_ID_pc_plus4, e.pc4);
                    check("IF_ID_instr", bus.IF_ID_instr, e.instr);
                    check("IF_ID_valid", 32'(bus.IF_ID_valid), 32'(e.valid));
                    check("stage_state", 32'(bus.stage_state), 32'(e.state));
                    check("stall_timeout", 32'(bus.stall_timeout), 32'(e.to));
                    check("stall_cnt", 32'(bus.stall_cnt), 32'(e.scnt));
                    check("flush_cnt", 32'(bus.flush_cnt), 32'(e.fcnt));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int burst;
        int r;
        bit pw, iw, fl;
        bus.pc_write = 0; bus.IF_ID_write = 0; bus.flush = 0;
        bus.branch_target = 0; bus.instr_in = 0;
        model_reset();

        // Two cycles held in reset, then free-run.
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        release_rst();
        repeat (3) step(1, 1, 0, 32'h0);
        settle();
        check("a_pc_after_3", bus.pc, 32'hC);
        check("a_pc4_after_3", bus.IF_ID_pc_plus4, 32'hC);
        check("a_valid_after_3", 32'(bus.IF_ID_valid), 32'd1);
        check("a_state_run", 32'(bus.stage_state), 32'd0);

        // Load-use stall at 0x10.
        step(1, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        settle();
        check("a_stall_pc", bus.pc, 32'h10);
        check("a_stall_pc4", bus.IF_ID_pc_plus4, 32'h10);
        check("a_stall_state", 32'(bus.stage_state), 32'd1);
        step(1, 1, 0, 32'h0);
        settle();
        check("a_after_stall_pc", bus.pc, 32'h14);

        // Taken branch at 0x20.
        repeat (3) step(1, 1, 0, 32'h0);
        step(1, 1, 1, 32'h100);
        settle();
        check("a_flush_pc", bus.pc, 32'h100);
        check("a_flush_instr", bus.IF_ID_instr, 32'h0);
        check("a_flush_valid", 32'(bus.IF_ID_valid), 32'd0);
        check("a_flush_state", 32'(bus.stage_state), 32'd2);
        step(1, 1, 0, 32'h0);
        settle();
        check("a_post_flush_pc", bus.pc, 32'h104);
        check("a_post_flush_state", 32'(bus.stage_state), 32'd0);

        // Stall beats flush, then the released flush redirects.
        step(0, 0, 1, 32'h200);
        settle();
        check("a_sbf_pc", bus.pc, 32'h104);
        check("a_sbf_state", 32'(bus.stage_state), 32'd1);
        step(1, 1, 1, 32'h200);
        settle();
        check("a_sbf_release_pc", bus.pc, 32'h200);
        check("a_sbf_release_valid", 32'(bus.IF_ID_valid), 32'd0);

        // PC wrap.
        step(1, 1, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 32'h0);
        settle();
        check("a_wrap_pc", bus.pc, 32'h0);
        check("a_wrap_pc4", bus.IF_ID_pc_plus4, 32'h0);

        // Watchdog trips on the 8th consecutive stall and is sticky.
        repeat (7) step(0, 0, 0, 32'h0);
        settle();
        check("a_wd_7", 32'(bus.stall_timeout), 32'd0);
        step(0, 0, 0, 32'h0);
        settle();
        check("a_wd_8", 32'(bus.stall_timeout), 32'd1);
        repeat (2) step(1, 1, 0, 32'h0);
        settle();
        check("a_wd_sticky", 32'(bus.stall_timeout), 32'd1);
        repeat (3) step(0, 0, 0, 32'h0);
        async_rst();
        #1;
        check("a_wd_async_clear", 32'(bus.stall_timeout), 32'd0);
        check("a_async_pc", bus.pc, 32'h0);
        step(0, 0, 1, 32'h300);
        release_rst();
        step(1, 1, 0, 32'h0);
        settle();
        check("a_restart_pc", bus.pc, 32'h4);

        // Randomized traffic with stall bursts and one mid-run reset.
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_rst();
                step(1, 1, 0, 32'h0);
                release_rst();
            end
            if (burst > 0) begin
                pw = 0; iw = 0; burst--;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 5) burst = $urandom_range(1, 12);
                pw = (r >= 15);
                iw = pw ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) == 0);
            end
            fl = ($urandom_range(0, 6) == 0);
            step(pw, iw, fl, $urandom() & 32'hFFFF_FFFC);
        end

        settle();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
